// File: rtl/biriscv_mem_pkg.sv
// Shared constants and types for the biriscv memory/GPIO subsystem.
// Address map, bank geometry and region decode enum.
package biriscv_mem_pkg;
  localparam int DEPTH = 512;
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] FRAM_BASE = 32'h1000_0000;
  localparam logic [31:0] GPIO_BASE = 32'h2000_0000;

  localparam logic [11:0] GPIO_OUT_OFF = 12'h000;
  localparam logic [11:0] GPIO_IN_OFF  = 12'h008;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_FRAM,
    REG_GPIO,
    REG_NONE
  } region_e;
endpackage

// File: rtl/biriscv_mem_bank.sv
// DEPTH x 64 storage bank with byte-strobed write and registered read.
// The array is never reset so contents survive resetn pulses.
module biriscv_mem_bank
  import biriscv_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [63:0]      wdata,
  input  logic [7:0]       wstrb,
  output logic [63:0]      rdata
);
  logic [63:0] ram [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst_n && en && we) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read sees pre-write contents on a same-edge write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (en) rdata <= ram[idx];
  end
endmodule

// File: rtl/biriscv_mem_gpio_sys.sv
// Memory + GPIO subsystem: address decode, two banks, GPIO regs,
// input synchroniser and one-cycle response register.
module biriscv_mem_gpio_sys
  import biriscv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  input  logic [7:0]  gpio_pin_in,
  output logic [7:0]  gpio_pin_out
);
  region_e          region;
  region_e          rsp_region;
  logic [IDX_W-1:0] idx;
  logic [63:0]      ram_q;
  logic [63:0]      fram_q;
  logic [7:0]       gpio_rd;
  logic [7:0]       rsp_gpio;
  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic             rsp_rd;
  logic             unused_addr;

  assign req_ready   = 1'b1;
  assign idx         = req_addr[11:3];
  assign unused_addr = ^req_addr[2:0];

  always_comb begin
    region = REG_NONE;
    if (req_addr[31:12] == RAM_BASE[31:12])
      region = REG_RAM;
    else if (req_addr[31:12] == FRAM_BASE[31:12])
      region = REG_FRAM;
    else if (req_addr[31:12] == GPIO_BASE[31:12])
      region = REG_GPIO;
  end

  biriscv_mem_bank u_ram (
    .clk   (clk),
    .rst_n (resetn),
    .en    (req_valid && region == REG_RAM),
    .we    (req_we),
    .idx   (idx),
    .wdata (req_wdata),
    .wstrb (req_wstrb),
    .rdata (ram_q)
  );

  biriscv_mem_bank u_fram (
    .clk   (clk),
    .rst_n (resetn),
    .en    (req_valid && region == REG_FRAM),
    .we    (req_we),
    .idx   (idx),
    .wdata (req_wdata),
    .wstrb (req_wstrb),
    .rdata (fram_q)
  );

  always_comb begin
    gpio_rd = '0;
    if (idx == GPIO_OUT_OFF[11:3])
      gpio_rd = gpio_pin_out;
    else if (idx == GPIO_IN_OFF[11:3])
      gpio_rd = sync2;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_pin_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpio_pin_out <= '0;
    end else if (req_valid && req_we && region == REG_GPIO
                 && idx == GPIO_OUT_OFF[11:3] && req_wstrb[0]) begin
      gpio_pin_out <= req_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rsp_rd     <= 1'b0;
      rsp_region <= REG_NONE;
      rsp_gpio   <= '0;
    end else begin
      resp_valid <= req_valid;
      resp_err   <= req_valid && region == REG_NONE;
      rsp_rd     <= req_valid && !req_we;
      rsp_region <= region;
      rsp_gpio   <= gpio_rd;
    end
  end

  // Bank read registers supply data; region tag picks the source
  always_comb begin
    resp_rdata = '0;
    if (resp_valid && rsp_rd) begin
      unique case (rsp_region)
        REG_RAM:  resp_rdata = ram_q;
        REG_FRAM: resp_rdata = fram_q;
        REG_GPIO: resp_rdata = {56'b0, rsp_gpio};
        default:  resp_rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_biriscv_mem_gpio_sys.sv
// Scoreboard bench for biriscv_mem_gpio_sys.
// Driver queues expected responses; a monitor pops and compares.
module tb_biriscv_mem_gpio_sys;
  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  gpio_pin_in;
  logic [7:0]  gpio_pin_out;

  int passed = 0;
  int total  = 0;
  logic [64:0] sb [$];

  biriscv_mem_gpio_sys dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .gpio_pin_in  (gpio_pin_in),
    .gpio_pin_out (gpio_pin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic req(input logic we, input logic [31:0] addr,
                     input logic [63:0] wdata, input logic [7:0] wstrb,
                     input logic [63:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    sb.push_back({exp_err, exp_rdata});
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wstrb = '0;
  endtask

  // Monitor: every response must match the oldest queued expectation
  always @(negedge clk) begin
    logic [64:0] e;
    if (resetn && resp_valid) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_resp: got rdata %h err %b expected none",
                 resp_rdata, resp_err);
      end else begin
        e = sb.pop_front();
        total++;
        if (resp_rdata === e[63:0] && resp_err === e[64]) passed++;
        else $display("FAIL resp#%0d: got rdata %h err %b expected %h err %b",
                      total, resp_rdata, resp_err, e[63:0], e[64]);
      end
    end
  end

  initial begin
    resetn      = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    gpio_pin_in = '0;
    for (int i = 0; i < 512; i++) begin
      dut.u_ram.ram[i]  = '0;
      dut.u_fram.ram[i] = '0;
    end

    // Request held during reset must not be performed
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h28;
    req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
    req_wstrb = 8'hFF;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    resetn    = 1'b1;
    #1;
    check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_gpio_out", {56'b0, gpio_pin_out}, 64'd0);
    check("rst_ram5", dut.u_ram.ram[5], 64'd0);
    @(negedge clk);
    check("post_rst_no_resp", {63'b0, resp_valid}, 64'd0);

    req(1'b1, 32'h28, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 1'b0);
    req(1'b0, 32'h28, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0);
    idle();
    check("bd_ram5", dut.u_ram.ram[5], 64'h0123_4567_89AB_CDEF);

    req(1'b0, 32'h1000_0010, 64'd0, 8'h00, 64'd0, 1'b0);
    req(1'b1, 32'h1000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81, 64'd0, 1'b0);
    req(1'b0, 32'h1000_0010, 64'd0, 8'h00, 64'hFF00_0000_0000_00FF, 1'b0);
    idle();
    idle();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("fram2_persist", dut.u_fram.ram[2], 64'hFF00_0000_0000_00FF);
    check("ram5_persist", dut.u_ram.ram[5], 64'h0123_4567_89AB_CDEF);

    req(1'b1, 32'h2000_0000, 64'h0000_0000_0000_00A5, 8'h01, 64'd0, 1'b0);
    idle();
    check("gpio_out_a5", {56'b0, gpio_pin_out}, 64'hA5);
    gpio_pin_in = 8'h3C;
    idle();
    req(1'b0, 32'h2000_0008, 64'd0, 8'h00, 64'h3C, 1'b0);
    req(1'b1, 32'h2000_0008, 64'hFF, 8'hFF, 64'd0, 1'b0);
    req(1'b1, 32'h2000_0000, 64'h00, 8'h00, 64'd0, 1'b0);
    req(1'b0, 32'h2000_0000, 64'd0, 8'h00, 64'hA5, 1'b0);
    req(1'b0, 32'h2000_0010, 64'd0, 8'h00, 64'd0, 1'b0);
    req(1'b0, 32'h2000_0008, 64'd0, 8'h00, 64'h3C, 1'b0);

    req(1'b0, 32'h3000_0000, 64'd0, 8'h00, 64'd0, 1'b1);
    req(1'b1, 32'h3000_0000, 64'h1234, 8'hFF, 64'd0, 1'b1);

    req(1'b1, 32'h8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'd0, 1'b0);
    req(1'b0, 32'h8, 64'd0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    req(1'b0, 32'h28, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0);
    idle();
    idle();
    check("gpio_out_hold", {56'b0, gpio_pin_out}, 64'hA5);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("idle_rdata_zero", resp_rdata, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
